// File: rtl/image_loader.sv
// image_loader: 8N1 UART receiver that writes a raw 8-bit pixel stream into the shared data memory.
// Define IMAGE_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the image.
module image_loader #(
    parameter int          CLKS_PER_BIT = 434,
    parameter logic [31:0] BASE_ADDR    = 32'd0,
    parameter int          IMG_BYTES    = 65536
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    input  logic        start,
    input  logic        abort,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data,
    output logic        mem_we,
    output logic        busy,
    output logic        done,
    output logic        err
);
    localparam int            CW      = $clog2(CLKS_PER_BIT);
    localparam int            NW      = $clog2(IMG_BYTES + 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [NW-1:0] LAST_N  = NW'(IMG_BYTES - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {
        L_IDLE,
        L_LOAD,
`ifdef IMAGE_LOADER_CHECKSUM_EN
        L_CHECK,
`endif
        L_FIN
    } load_state_t;

    logic          rx_meta, rx_sync, rx_prev;
    logic          fall;
    rx_state_t     rx_state, rx_next;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          half_tick, bit_tick, byte_ok, frame_err;
    load_state_t   state, state_next;
    logic [NW-1:0] n;
    logic [7:0]    csum;

    // The synchronizer and edge history idle high so reset never looks like a start bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign fall      = rx_prev & ~rx_sync;
    assign half_tick = (cnt == HALF_M1);
    assign bit_tick  = (cnt == FULL_M1);
    assign byte_ok   = busy && (rx_state == RX_STOP) && bit_tick && rx_sync;
    assign frame_err = busy && (rx_state == RX_STOP) && bit_tick && !rx_sync;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_state <= RX_IDLE;
        end else begin
            rx_state <= rx_next;
        end
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:  if (fall) rx_next = RX_START;
            RX_START: if (half_tick) rx_next = rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:  if (bit_tick && bit_idx == 3'd7) rx_next = RX_STOP;
            RX_STOP:  if (bit_tick) rx_next = RX_IDLE;
            default:  rx_next = RX_IDLE;
        endcase
        if (!busy) rx_next = RX_IDLE;
    end

    // Bit timer restarts on every state change so DATA/STOP samples land mid-bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            if (rx_state == RX_IDLE || rx_next != rx_state || bit_tick) cnt <= '0;
            else cnt <= cnt + 1'b1;
            if (rx_state == RX_START) bit_idx <= '0;
            if (rx_state == RX_DATA && bit_tick) begin
                shreg   <= {rx_sync, shreg[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= L_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            L_IDLE: if (start) state_next = L_LOAD;
            L_LOAD: begin
                if (abort || frame_err) state_next = L_IDLE;
`ifdef IMAGE_LOADER_CHECKSUM_EN
                else if (byte_ok && n == LAST_N) state_next = L_CHECK;
`else
                else if (byte_ok && n == LAST_N) state_next = L_FIN;
`endif
            end
`ifdef IMAGE_LOADER_CHECKSUM_EN
            L_CHECK: if (abort || byte_ok || frame_err) state_next = L_IDLE;
`endif
            L_FIN:   state_next = L_IDLE;
            default: state_next = L_IDLE;
        endcase
    end

    // Abort takes priority over a byte completing in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_addr <= '0;
            mem_data <= '0;
            mem_we   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            n        <= '0;
            csum     <= '0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                L_IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        done <= 1'b0;
                        err  <= 1'b0;
                        n    <= '0;
                        csum <= '0;
                    end
                end
                L_LOAD: begin
                    if (abort) begin
                        busy <= 1'b0;
                    end else if (frame_err) begin
                        err  <= 1'b1;
                        busy <= 1'b0;
                    end else if (byte_ok) begin
                        mem_we   <= 1'b1;
                        mem_addr <= BASE_ADDR + 32'(n);
                        mem_data <= {24'b0, shreg};
                        n        <= n + 1'b1;
                        csum     <= csum ^ shreg;
                    end
                end
`ifdef IMAGE_LOADER_CHECKSUM_EN
                L_CHECK: begin
                    if (abort) begin
                        busy <= 1'b0;
                    end else if (frame_err) begin
                        err  <= 1'b1;
                        busy <= 1'b0;
                    end else if (byte_ok) begin
                        if (shreg == csum) done <= 1'b1;
                        else err <= 1'b1;
                        busy <= 1'b0;
                    end
                end
`endif
                L_FIN: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_image_loader.sv
// Directed bench for image_loader: a byte-level model predicts writes and status flags.
module tb_image_loader;
    localparam int          CPB  = 4;
    localparam logic [31:0] BASE = 32'h100;
    localparam int          IMG  = 4;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic        rx    = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] mem_addr, mem_data;
    logic        mem_we, busy, done, err;

    image_loader #(.CLKS_PER_BIT(CPB), .BASE_ADDR(BASE), .IMG_BYTES(IMG)) dut (
        .clk(clk), .reset(reset), .rx(rx), .start(start), .abort(abort),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int          write_count = 0;
    logic [31:0] last_addr = '0;
    logic [31:0] last_data = '0;
    logic        prev_we = 1'b0;
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];

    bit          m_busy = 0, m_done = 0, m_err = 0, m_in_check = 0;
    int          m_n = 0;
    logic [7:0]  m_csum = '0;

    task automatic check_word(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic check_bit(input string name, input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
        end
    endtask

    // Every write strobe must match the next write the model predicted, in order.
    always @(negedge clk) begin
        if (reset && mem_we) begin
            write_count++;
            last_addr = mem_addr;
            last_data = mem_data;
            if (exp_addr_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write", mem_addr, mem_data);
            end else begin
                check_word("write_addr", mem_addr, exp_addr_q.pop_front());
                check_word("write_data", mem_data, exp_data_q.pop_front());
            end
            check_bit("we_single_cycle", prev_we, 1'b0);
        end
        prev_we = mem_we;
    end

    task automatic model_start();
        if (!m_busy) begin
            m_busy = 1; m_done = 0; m_err = 0; m_in_check = 0; m_n = 0; m_csum = '0;
        end
    endtask

    task automatic model_abort();
        if (m_busy) m_busy = 0;
    endtask

    task automatic model_reset();
        m_busy = 0; m_done = 0; m_err = 0; m_in_check = 0;
    endtask

    task automatic model_byte(input logic [7:0] b, input logic stop_bit);
        if (!m_busy) return;
        if (!stop_bit) begin
            m_err = 1; m_busy = 0;
            return;
        end
        if (m_in_check) begin
            if (b == m_csum) m_done = 1;
            else m_err = 1;
            m_busy = 0;
            return;
        end
        exp_addr_q.push_back(BASE + 32'(m_n));
        exp_data_q.push_back({24'b0, b});
        m_n++;
        m_csum ^= b;
        if (m_n == IMG) begin
`ifdef IMAGE_LOADER_CHECKSUM_EN
            m_in_check = 1;
`else
            m_done = 1; m_busy = 0;
`endif
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic apply_stimulus(input logic [7:0] b, input logic stop_bit);
        model_byte(b, stop_bit);
        send_frame(b, stop_bit);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        model_start();
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        model_abort();
        @(negedge clk);
        abort = 1'b0;
    endtask

    task automatic pulse_both();
        start = 1'b1;
        abort = 1'b1;
        if (!m_busy) model_start();
        else model_abort();
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic check_output(input string tag);
        check_bit({tag, "_busy"}, busy, m_busy);
        check_bit({tag, "_done"}, done, m_done);
        check_bit({tag, "_err"}, err, m_err);
    endtask

    task automatic settle();
        repeat (8) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        check_word("rst_addr", mem_addr, 32'h0);
        check_word("rst_data", mem_data, 32'h0);
        check_bit("rst_we", mem_we, 1'b0);
        check_output("rst");
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_output("post_rst");
        check_bit("post_rst_we", mem_we, 1'b0);

        $display("[TB] rx traffic while idle");
        apply_stimulus(8'h77, 1'b1);
        settle();
        check_output("idle_rx");
        check_word("idle_rx_writes", write_count, 0);

        $display("[TB] full image load");
        check_bit("busy_before_start", busy, 1'b0);
        pulse_start();
        check_bit("busy_after_start", busy, 1'b1);
        apply_stimulus(8'h11, 1'b1);
        apply_stimulus(8'h22, 1'b1);
        apply_stimulus(8'h33, 1'b1);
        apply_stimulus(8'h44, 1'b1);
`ifdef IMAGE_LOADER_CHECKSUM_EN
        apply_stimulus(m_csum, 1'b1);
`endif
        settle();
        check_output("img1");
        check_word("img1_writes", write_count, 4);
        check_word("img1_last_addr", last_addr, 32'h103);
        check_word("img1_last_data", last_data, 32'h44);
        check_bit("img1_done_literal", done, 1'b1);

        $display("[TB] framing error");
        pulse_start();
        apply_stimulus(8'hA5, 1'b0);
        settle();
        check_output("frame");
        check_bit("frame_err_literal", err, 1'b1);
        check_word("frame_writes", write_count, 4);
        pulse_start();
        check_output("restart");

        $display("[TB] abort after two bytes");
        apply_stimulus(8'h5A, 1'b1);
        apply_stimulus(8'hC3, 1'b1);
        repeat (4) @(negedge clk);
        pulse_abort();
        repeat (2) @(negedge clk);
        check_output("abort");
        check_word("abort_writes", write_count, 6);
        check_word("abort_last_addr", last_addr, 32'h101);
        check_word("abort_last_data", last_data, 32'hC3);

        $display("[TB] start and abort together");
        pulse_both();
        check_output("both_idle");
        pulse_both();
        check_output("both_busy");

        $display("[TB] rx glitch while busy");
        pulse_start();
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (60) @(negedge clk);
        check_output("glitch");
        check_word("glitch_writes", write_count, 6);
        pulse_abort();
        repeat (2) @(negedge clk);

        $display("[TB] reset mid-byte");
        pulse_start();
        apply_stimulus(8'h3C, 1'b1);
        fork
            send_frame(8'hE7, 1'b1);
            begin
                repeat (15) @(negedge clk);
                reset = 1'b0;
                model_reset();
                repeat (3) @(negedge clk);
                reset = 1'b1;
            end
        join
        settle();
        check_output("midrst");
        check_word("midrst_writes", write_count, 7);
        check_word("midrst_addr", mem_addr, 32'h0);
        check_word("midrst_data", mem_data, 32'h0);

`ifdef IMAGE_LOADER_CHECKSUM_EN
        $display("[TB] checksum good");
        pulse_start();
        apply_stimulus(8'h01, 1'b1);
        apply_stimulus(8'h02, 1'b1);
        apply_stimulus(8'h04, 1'b1);
        apply_stimulus(8'h08, 1'b1);
        apply_stimulus(8'h0F, 1'b1);
        settle();
        check_output("csum_ok");
        check_bit("csum_ok_done_literal", done, 1'b1);
        check_word("csum_ok_writes", write_count, 11);

        $display("[TB] checksum bad");
        pulse_start();
        apply_stimulus(8'h01, 1'b1);
        apply_stimulus(8'h02, 1'b1);
        apply_stimulus(8'h04, 1'b1);
        apply_stimulus(8'h08, 1'b1);
        apply_stimulus(8'h0E, 1'b1);
        settle();
        check_output("csum_bad");
        check_bit("csum_bad_err_literal", err, 1'b1);
        check_word("csum_bad_writes", write_count, 15);
`endif

        check_word("pending_writes", exp_addr_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
